m3_dequant: RTL and testbench
=============================

M3_DEQUANT -- requirements
Module: m3_dequant

Interface
REQ-001 SHALL have parameter PRE_IDCT_OFFSET, default 18'd76800; base SRAM word address of the Y pre-IDCT region.
REQ-002 SHALL have parameter U_PRE_OFFSET, default 18'd153600; base SRAM word address of the U pre-IDCT region.
REQ-003 SHALL have parameter V_PRE_OFFSET, default 18'd192000; base SRAM word address of the V pre-IDCT region.
REQ-004 CLOCK_50_I  in  1  sole clock, all logic on posedge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 m3_start  in  1  one-cycle start pulse, accepted only in IDLE.
REQ-007 quant_sel  in  1  quantization matrix select (0=Q0, 1=Q1), sampled when m3_start is accepted.
REQ-008 coeff_data  in  16  signed quantized coefficient, zig-zag order within the 8x8 block.
REQ-009 coeff_eob  in  1  end-of-block marker, qualified with coeff_valid.
REQ-010 coeff_valid  in  1  upstream decoder has a coefficient.
REQ-011 coeff_ready  out  1  block accepts a coefficient this cycle.
REQ-012 SRAM_address  out  18  SRAM word address.
REQ-013 SRAM_write_data  out  16  dequantized coefficient.
REQ-014 write_en_n  out  1  SRAM write enable, active low.
REQ-015 m3_finish  out  1  one-cycle pulse after the last write of the frame.

Function
REQ-016 SHALL implement states IDLE, RUN, ZFILL, DONE; IDLE->RUN on m3_start, RUN->ZFILL on accepted eob with index<63, ZFILL->RUN after filling index 63, RUN/ZFILL->DONE after last write of block 2399, DONE->IDLE after one cycle.
REQ-017 Transfer occurs on the edge where coeff_valid=1 and coeff_ready=1; coeff_ready SHALL be 1 only in RUN.
REQ-018 Zig-zag index k (0..63) SHALL map through a fixed 64-entry JPEG zig-zag LUT to (r,c); k resets to 0 at each block start.
REQ-019 Dequant SHALL be an arithmetic left shift by s(d), d=r+c; Q0: d0:3, d1:2, d2:3, d3:3, d4:4, d5:4, d6-7:5, d>=8:6; Q1: d0:3, d1-3:1, d4-5:2, d6-7:3, d>=8:4.
REQ-020 Block order: Y 40x30 blocks (stride 320), then U 20x30 (stride 160), then V 20x30 (stride 160), row-major, 2400 blocks total.
REQ-021 Address SHALL be plane_base + (8*block_row + r)*stride + 8*block_col + c.
REQ-022 On the accepting edge, SRAM_address/SRAM_write_data SHALL be registered and write_en_n driven 0 for exactly the next cycle; throughput one write per cycle.
REQ-023 Accepted eob at index k<63 SHALL write coefficient k, then zero-fill indices k+1..63, one write per cycle, coeff_ready=0 throughout.
REQ-024 Eob at k=63, or no eob, SHALL end the block after index 63 with no fill cycles.
REQ-025 write_en_n SHALL be 1 in every non-writing cycle; m3_start outside IDLE SHALL be ignored.
REQ-026 m3_finish SHALL assert in DONE, the cycle after the final write (V block 599, index 63).

Reset
REQ-027 Reset SHALL force IDLE, all counters 0, coeff_ready=0, SRAM_address=0, SRAM_write_data=0, write_en_n=1, m3_finish=0.
REQ-028 Reset mid-frame SHALL abort at once with no further writes; next m3_start restarts at Y block 0.

Configuration
REQ-029 With M3_SAT_EN defined, shifted results SHALL saturate to [-32768, 32767]; without it, the low 16 bits are written (wrap).

Verification
REQ-030 Reset held 2 cycles during RUN -> all outputs at REQ-027 values next cycle, no write pulses.
REQ-031 quant_sel=0, first coeff 5 at k=0 -> address 76800, data 40; k=1 coeff -3 -> address 76801, data -12.
REQ-032 Eob with k=2 on Y block 0 -> 61 zero writes, last at 76800+7*320+7=79047, coeff_ready low for 61 cycles.
REQ-033 quant_sel=1, k=63 coeff 4000 -> data 64000 wraps to -1536 without M3_SAT_EN, 32767 with it.
REQ-034 First U block k=0 -> address 153600; V block 599 k=63 -> address 230399, m3_finish pulse next cycle.
REQ-035 coeff_valid toggled randomly for one block -> exactly 64 writes, correct order, none on non-accepting cycles.

Source files
------------

// File: rtl/m3_dequant.sv
`default_nettype none
// ============================================================================
// Module   : m3_dequant
// Brief    : Accepts zig-zag ordered quantized coefficients for a frame of
//            8x8 blocks (Y, then U, then V), dequantizes each with a
//            diagonal-dependent left shift and writes it to its position
//            in the pre-IDCT SRAM region. A block that ends early with an
//            end-of-block marker is completed with zero writes.
// Options  : define M3_SAT_EN to saturate shifted results to 16 bits
//            (default build writes the low 16 bits, i.e. wraps).
// Revision : 1.0 - initial release
// ============================================================================
module m3_dequant #(
  parameter logic [17:0] PRE_IDCT_OFFSET = 18'd76800,
  parameter logic [17:0] U_PRE_OFFSET    = 18'd153600,
  parameter logic [17:0] V_PRE_OFFSET    = 18'd192000,
  // Frame geometry in blocks; chroma planes are half the luma width.
  parameter int          Y_BLOCK_COLS    = 40,
  parameter int          BLOCK_ROWS      = 30
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        m3_start,
  input  logic        quant_sel,
  input  logic [15:0] coeff_data,
  input  logic        coeff_eob,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        write_en_n,
  output logic        m3_finish
);

  localparam logic [1:0]  c_S_IDLE     = 2'd0;
  localparam logic [1:0]  c_S_RUN      = 2'd1;
  localparam logic [1:0]  c_S_ZFILL    = 2'd2;
  localparam logic [1:0]  c_S_DONE     = 2'd3;

  localparam logic [7:0]  c_Y_COL_LAST = 8'(Y_BLOCK_COLS - 1);
  localparam logic [7:0]  c_C_COL_LAST = 8'(Y_BLOCK_COLS / 2 - 1);
  localparam logic [7:0]  c_ROW_LAST   = 8'(BLOCK_ROWS - 1);
  localparam logic [17:0] c_Y_STRIDE   = 18'(8 * Y_BLOCK_COLS);
  localparam logic [17:0] c_C_STRIDE   = 18'(4 * Y_BLOCK_COLS);
  localparam logic [5:0]  c_K_LAST     = 6'd63;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [5:0]  r_k;
  logic [7:0]  r_blk_col;
  logic [7:0]  r_blk_row;
  logic [1:0]  r_plane;
  logic        r_qsel;
  logic        r_frame_end;

  logic        w_ready;
  logic        w_accept;
  logic        w_fill;
  logic        w_wr;
  logic [7:0]  w_col_last;
  logic        w_frame_last;
  logic [5:0]  w_pos;
  logic [2:0]  w_r;
  logic [2:0]  w_c;
  logic [3:0]  w_diag;
  logic [2:0]  w_shift;
  logic [17:0] w_base;
  logic [17:0] w_stride;
  logic [17:0] w_row;
  logic [17:0] w_col_off;
  logic [17:0] w_addr;
  logic [21:0] w_ext;
  logic [21:0] w_shifted;
  logic [15:0] w_q;
  logic [15:0] w_data;

  // JPEG zig-zag scan: index k -> raster position r*8+c inside the block.
  function automatic logic [5:0] f_zigzag(input logic [5:0] k);
    logic [5:0] p;
    case (k)
      6'd0:  p = 6'd0;   6'd1:  p = 6'd1;   6'd2:  p = 6'd8;   6'd3:  p = 6'd16;
      6'd4:  p = 6'd9;   6'd5:  p = 6'd2;   6'd6:  p = 6'd3;   6'd7:  p = 6'd10;
      6'd8:  p = 6'd17;  6'd9:  p = 6'd24;  6'd10: p = 6'd32;  6'd11: p = 6'd25;
      6'd12: p = 6'd18;  6'd13: p = 6'd11;  6'd14: p = 6'd4;   6'd15: p = 6'd5;
      6'd16: p = 6'd12;  6'd17: p = 6'd19;  6'd18: p = 6'd26;  6'd19: p = 6'd33;
      6'd20: p = 6'd40;  6'd21: p = 6'd48;  6'd22: p = 6'd41;  6'd23: p = 6'd34;
      6'd24: p = 6'd27;  6'd25: p = 6'd20;  6'd26: p = 6'd13;  6'd27: p = 6'd6;
      6'd28: p = 6'd7;   6'd29: p = 6'd14;  6'd30: p = 6'd21;  6'd31: p = 6'd28;
      6'd32: p = 6'd35;  6'd33: p = 6'd42;  6'd34: p = 6'd49;  6'd35: p = 6'd56;
      6'd36: p = 6'd57;  6'd37: p = 6'd50;  6'd38: p = 6'd43;  6'd39: p = 6'd36;
      6'd40: p = 6'd29;  6'd41: p = 6'd22;  6'd42: p = 6'd15;  6'd43: p = 6'd23;
      6'd44: p = 6'd30;  6'd45: p = 6'd37;  6'd46: p = 6'd44;  6'd47: p = 6'd51;
      6'd48: p = 6'd58;  6'd49: p = 6'd59;  6'd50: p = 6'd52;  6'd51: p = 6'd45;
      6'd52: p = 6'd38;  6'd53: p = 6'd31;  6'd54: p = 6'd39;  6'd55: p = 6'd46;
      6'd56: p = 6'd53;  6'd57: p = 6'd60;  6'd58: p = 6'd61;  6'd59: p = 6'd54;
      6'd60: p = 6'd47;  6'd61: p = 6'd55;  6'd62: p = 6'd62;  default: p = 6'd63;
    endcase
    return p;
  endfunction

  // Shift amount per anti-diagonal d=r+c for the two quantization matrices.
  function automatic logic [2:0] f_shift(input logic q, input logic [3:0] d);
    logic [2:0] s;
    if (!q) begin
      case (d)
        4'd0:        s = 3'd3;
        4'd1:        s = 3'd2;
        4'd2, 4'd3:  s = 3'd3;
        4'd4, 4'd5:  s = 3'd4;
        4'd6, 4'd7:  s = 3'd5;
        default:     s = 3'd6;
      endcase
    end else begin
      case (d)
        4'd0:              s = 3'd3;
        4'd1, 4'd2, 4'd3:  s = 3'd1;
        4'd4, 4'd5:        s = 3'd2;
        4'd6, 4'd7:        s = 3'd3;
        default:           s = 3'd4;
      endcase
    end
    return s;
  endfunction

  // Write qualification, block/frame position and address/data generation.
  always_comb begin
    w_ready      = (r_state == c_S_RUN) && !r_frame_end;
    w_accept     = w_ready && coeff_valid;
    w_fill       = (r_state == c_S_ZFILL);
    w_wr         = w_accept || w_fill;
    w_col_last   = (r_plane == 2'd0) ? c_Y_COL_LAST : c_C_COL_LAST;
    w_frame_last = (r_plane == 2'd2) && (r_blk_row == c_ROW_LAST) &&
                   (r_blk_col == w_col_last);

    w_pos        = f_zigzag(r_k);
    w_r          = w_pos[5:3];
    w_c          = w_pos[2:0];
    w_diag       = {1'b0, w_r} + {1'b0, w_c};
    w_shift      = f_shift(r_qsel, w_diag);

    case (r_plane)
      2'd0:    begin w_base = PRE_IDCT_OFFSET; w_stride = c_Y_STRIDE; end
      2'd1:    begin w_base = U_PRE_OFFSET;    w_stride = c_C_STRIDE; end
      default: begin w_base = V_PRE_OFFSET;    w_stride = c_C_STRIDE; end
    endcase
    w_row        = {7'd0, r_blk_row, 3'd0} + {15'd0, w_r};
    w_col_off    = {7'd0, r_blk_col, 3'd0} + {15'd0, w_c};
    w_addr       = w_base + w_row * w_stride + w_col_off;

    // Shift of at most 6 on a 16-bit value always fits in 22 bits.
    w_ext        = {{6{coeff_data[15]}}, coeff_data};
    w_shifted    = w_ext << w_shift;
`ifdef M3_SAT_EN
    if (w_shifted[21:15] == {7{w_shifted[21]}}) begin
      w_q = w_shifted[15:0];
    end else if (w_shifted[21]) begin
      w_q = 16'h8000;
    end else begin
      w_q = 16'h7FFF;
    end
`else
    w_q          = w_shifted[15:0];
`endif
    w_data       = w_fill ? 16'd0 : w_q;
  end

  // State register.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a frame ends one cycle after its final write is issued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (m3_start) begin
          w_state_next = c_S_RUN;
        end
      end
      c_S_RUN: begin
        if (r_frame_end) begin
          w_state_next = c_S_DONE;
        end else if (w_accept && coeff_eob && (r_k != c_K_LAST)) begin
          w_state_next = c_S_ZFILL;
        end
      end
      c_S_ZFILL: begin
        if (r_k == c_K_LAST) begin
          w_state_next = c_S_RUN;
        end
      end
      default: begin
        w_state_next = c_S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    coeff_ready = w_ready;
    m3_finish   = (r_state == c_S_DONE);
  end

  // Counters, block walk and the registered SRAM write port.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_k             <= 6'd0;
      r_blk_col       <= 8'd0;
      r_blk_row       <= 8'd0;
      r_plane         <= 2'd0;
      r_qsel          <= 1'b0;
      r_frame_end     <= 1'b0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      write_en_n      <= 1'b1;
    end else begin
      write_en_n <= ~w_wr;
      if (w_wr) begin
        SRAM_address    <= w_addr;
        SRAM_write_data <= w_data;
      end
      if (r_state == c_S_IDLE) begin
        if (m3_start) begin
          r_qsel      <= quant_sel;
          r_k         <= 6'd0;
          r_blk_col   <= 8'd0;
          r_blk_row   <= 8'd0;
          r_plane     <= 2'd0;
          r_frame_end <= 1'b0;
        end
      end else if (r_state == c_S_DONE) begin
        r_frame_end <= 1'b0;
      end else if (w_wr) begin
        if (r_k == c_K_LAST) begin
          r_k <= 6'd0;
          if (w_frame_last) begin
            r_frame_end <= 1'b1;
          end else if (r_blk_col == w_col_last) begin
            r_blk_col <= 8'd0;
            if (r_blk_row == c_ROW_LAST) begin
              r_blk_row <= 8'd0;
              r_plane   <= r_plane + 2'd1;
            end else begin
              r_blk_row <= r_blk_row + 8'd1;
            end
          end else begin
            r_blk_col <= r_blk_col + 8'd1;
          end
        end else begin
          r_k <= r_k + 6'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m3_dequant.sv
`default_nettype none
// ============================================================================
// Module   : tb_m3_dequant
// Brief    : Randomized scoreboard bench for m3_dequant. A reduced frame
//            height keeps the run short while luma/chroma strides stay at
//            their full-width values.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_m3_dequant;

  localparam int ROWS  = 2;
  localparam int YCOLS = 40;
  localparam int CCOLS = YCOLS / 2;
  localparam int NY    = YCOLS * ROWS;
  localparam int NC    = CCOLS * ROWS;
  localparam int NB    = NY + 2 * NC;

  logic        CLOCK_50_I = 1'b0;
  logic        Reset = 1'b1;
  logic        m3_start = 1'b0;
  logic        quant_sel = 1'b0;
  logic [15:0] coeff_data = 16'd0;
  logic        coeff_eob = 1'b0;
  logic        coeff_valid = 1'b0;
  logic        coeff_ready;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        write_en_n;
  logic        m3_finish;

  m3_dequant #(
    .Y_BLOCK_COLS (YCOLS),
    .BLOCK_ROWS   (ROWS)
  ) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .Reset           (Reset),
    .m3_start        (m3_start),
    .quant_sel       (quant_sel),
    .coeff_data      (coeff_data),
    .coeff_eob       (coeff_eob),
    .coeff_valid     (coeff_valid),
    .coeff_ready     (coeff_ready),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .write_en_n      (write_en_n),
    .m3_finish       (m3_finish)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  typedef struct {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail = 0;
  int  zz_r[64];
  int  zz_c[64];
  int  blk_c[64];
  int  cyc = 0;
  int  last_wr_cyc = -10;
  int  frame_writes = 0;
  int  finish_cnt = 0;
  bit  prev_finish = 1'b0;
  bit  at_neg = 1'b0;

  function automatic void check(string nm, longint act, longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  task automatic finish_sim();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Zig-zag order from walking anti-diagonals, alternating direction.
  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_r[k] = r; zz_c[k] = s - r; k++; end
      end
    end
  endtask

  function automatic int shift_of(int q, int d);
    if (q == 0) begin
      if (d == 0) return 3;
      if (d == 1) return 2;
      if (d <= 3) return 3;
      if (d <= 5) return 4;
      if (d <= 7) return 5;
      return 6;
    end
    if (d == 0) return 3;
    if (d <= 3) return 1;
    if (d <= 5) return 2;
    if (d <= 7) return 3;
    return 4;
  endfunction

  function automatic logic [15:0] dq(int coeff, int q, int k);
    int v = coeff * (1 << shift_of(q, zz_r[k] + zz_c[k]));
`ifdef M3_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  function automatic logic [17:0] addr_of(int b, int k);
    int base, cols, stride, lb;
    if (b < NY) begin
      base = 76800;  cols = YCOLS; stride = 320; lb = b;
    end else if (b < NY + NC) begin
      base = 153600; cols = CCOLS; stride = 160; lb = b - NY;
    end else begin
      base = 192000; cols = CCOLS; stride = 160; lb = b - NY - NC;
    end
    return 18'(base + (8 * (lb / cols) + zz_r[k]) * stride + 8 * (lb % cols) + zz_c[k]);
  endfunction

  task automatic push_write(int b, int k, int coeff, int q);
    wr_t e;
    e.a = addr_of(b, k);
    e.d = dq(coeff, q, k);
    exp_q.push_back(e);
  endtask

  // Monitor: every write pulse is matched against the scoreboard in order.
  always @(negedge CLOCK_50_I) begin
    cyc++;
    if (write_en_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", SRAM_address, $signed(SRAM_write_data));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", SRAM_address, mon_e.a);
        check("wr_data", $signed(SRAM_write_data), $signed(mon_e.d));
      end
      last_wr_cyc = cyc;
      frame_writes++;
    end
    if (prev_finish) check("finish_pulse_width", m3_finish, 0);
    if (m3_finish === 1'b1 && !prev_finish) begin
      finish_cnt++;
      check("finish_after_last_write", cyc - last_wr_cyc, 1);
      check("frame_write_count", frame_writes, NB * 64);
      check("finish_queue_empty", exp_q.size(), 0);
      frame_writes = 0;
    end
    prev_finish = m3_finish;
  end

  task automatic start_frame(int q);
    @(negedge CLOCK_50_I);
    m3_start = 1'b1; quant_sel = q[0]; coeff_valid = 1'b0;
    @(posedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    m3_start = 1'b0; quant_sel = ~q[0];
    check("ready_after_start", coeff_ready, 1);
    at_neg = 1'b1;
  endtask

  // Offers n coefficients with random valid gaps; stray starts must be ignored.
  task automatic send_block(int b, int q, int n, bit eob);
    for (int i = 0; i < n; i++) begin
      bit done = 1'b0;
      int budget = 0;
      while (!done) begin
        if (!at_neg) @(negedge CLOCK_50_I);
        at_neg = 1'b0;
        coeff_valid = (($urandom % 4) != 0);
        coeff_data  = 16'(blk_c[i]);
        coeff_eob   = eob && (i == n - 1);
        m3_start    = (($urandom % 20) == 0);
        quant_sel   = 1'($urandom);
        if (coeff_valid && coeff_ready) begin
          done = 1'b1;
          push_write(b, i, blk_c[i], q);
        end
        budget++;
        if (budget > 200) begin
          check("accept_timeout", 0, 1);
          finish_sim();
        end
        @(posedge CLOCK_50_I);
      end
    end
    if (eob && n < 64) begin
      int gap = 0;
      for (int k = n; k < 64; k++) push_write(b, k, 0, q);
      if (b != NB - 1) begin
        while (gap <= 100) begin
          @(negedge CLOCK_50_I);
          if (coeff_ready) break;
          coeff_valid = 1'($urandom);
          m3_start    = (($urandom % 20) == 0);
          gap++;
        end
        check("zfill_ready_low_cycles", gap, 64 - n);
        at_neg = 1'b1;
      end
    end
  endtask

  task automatic wait_finish();
    int t = 0;
    int c0;
    if (!at_neg) @(negedge CLOCK_50_I);
    at_neg = 1'b0;
    coeff_valid = 1'b0; m3_start = 1'b0; coeff_eob = 1'b0;
    c0 = finish_cnt;
    while (finish_cnt == c0 && t < 300) begin
      @(posedge CLOCK_50_I);
      t++;
    end
    check("frame_finish_seen", finish_cnt - c0, 1);
    repeat (3) @(posedge CLOCK_50_I);
    check("idle_ready_low", coeff_ready, 0);
  endtask

  task automatic rand_block(output int n, output bit eob);
    for (int i = 0; i < 64; i++) begin
      logic [15:0] t = 16'($urandom);
      blk_c[i] = ($urandom_range(0, 7) == 0) ? int'($signed(t)) : $urandom_range(0, 127) - 64;
    end
    n   = (($urandom % 3) == 0) ? 64 : 1 + int'($urandom % 64);
    eob = (n < 64) ? 1'b1 : 1'($urandom);
  endtask

  // mode 1: short first block with eob at k=2; mode 2: full first block with 4000 at k=63.
  task automatic run_frame(int q, int mode);
    int n;
    bit eob;
    start_frame(q);
    for (int b = 0; b < NB; b++) begin
      rand_block(n, eob);
      if (b == 0 && mode == 1) begin
        blk_c[0] = 5; blk_c[1] = -3; blk_c[2] = 7; n = 3; eob = 1'b1;
      end else if (b == 0 && mode == 2) begin
        blk_c[63] = 4000; n = 64; eob = 1'b0;
      end else if (b == 1 && mode == 2) begin
        n = 64; eob = 1'b1;
      end else if (b == NB - 1 && mode == 2) begin
        n = 64; eob = 1'b0;
      end
      send_block(b, q, n, eob);
    end
    wait_finish();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ready"}, coeff_ready, 0);
    check({tag, "_addr"}, SRAM_address, 0);
    check({tag, "_data"}, SRAM_write_data, 0);
    check({tag, "_wen"}, write_en_n, 1);
    check({tag, "_finish"}, m3_finish, 0);
  endtask

  initial begin
    int n;
    bit eob;
    build_zz();
    repeat (2) @(posedge CLOCK_50_I);
    #1 check_reset_outputs("por");
    @(negedge CLOCK_50_I);
    Reset = 1'b0;

    run_frame(0, 1);
    run_frame(1, 2);

    // Abort mid-block with a two-cycle reset, then restart from Y block 0.
    start_frame(0);
    rand_block(n, eob);
    send_block(0, 0, 10, 1'b0);
    @(negedge CLOCK_50_I);
    Reset = 1'b1; coeff_valid = 1'b0; m3_start = 1'b0;
    @(posedge CLOCK_50_I);
    #1 check_reset_outputs("rst1");
    exp_q.delete();
    frame_writes = 0;
    @(posedge CLOCK_50_I);
    #1 check_reset_outputs("rst2");
    @(negedge CLOCK_50_I);
    Reset = 1'b0;
    repeat (5) @(posedge CLOCK_50_I);
    #1 check_reset_outputs("post_rst");
    check("post_rst_no_finish", finish_cnt, 2);

    run_frame(0, 0);
    finish_sim();
  end

endmodule
`default_nettype wire
